// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU sharing controller: FSM encodings,
// ALU input-select codes, one-hot opcodes and the opcode validity check.
package alu_share_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;

    localparam logic [6:0] OP_ADD  = 7'b1000000;
    localparam logic [6:0] OP_SUB  = 7'b0100000;
    localparam logic [6:0] OP_AND  = 7'b0010000;
    localparam logic [6:0] OP_OR   = 7'b0001000;
    localparam logic [6:0] OP_XOR  = 7'b0000100;
    localparam logic [6:0] OP_NOT  = 7'b0000010;
    localparam logic [6:0] OP_PASS = 7'b0000001;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic onehot_check(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way request arbiter returning the winning requester index.
// ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties, no pointer input).
module alu_rr_arb2 (
    input  logic req0,
    input  logic req1,
`ifndef ARB_FIXED_PRIO_EN
    input  logic ptr,
`endif
    output logic valid,
    output logic win
);

    assign valid = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
    assign win = !req0;
`else
    // On a tie the pointer side wins; otherwise the lone requester wins.
    assign win = (req0 & req1) ? ptr : req1;
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer/arbiter sharing one ALU between two requesters (IDLE/LOAD/EXEC/RESP).
// Define ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int OPW         = 7,
    parameter int EXEC_CYCLES = 2   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [OPW-1:0]   op0,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1,
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPW-1:0]   alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [1:0]       state
);

    state_e             state_q;
    logic               winner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OPW-1:0]     op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               alu_on_q;
    logic [2:0]         in_sel_q;
    logic               busy_q;
    logic [1:0]         gnt_q;
    logic [1:0]         done_q;
    logic [1:0]         err_q;
    logic [WIDTH-1:0]   res_q [2];
`ifndef ARB_FIXED_PRIO_EN
    logic               ptr_q;
`endif

    logic               arb_valid;
    logic               arb_win;
    logic [OPW-1:0]     sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_ok;

    alu_rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
`ifndef ARB_FIXED_PRIO_EN
        .ptr   (ptr_q),
`endif
        .valid (arb_valid),
        .win   (arb_win)
    );

    assign sel_op = arb_win ? op1 : op0;
    assign sel_a  = arb_win ? a1  : a0;
    assign sel_b  = arb_win ? b1  : b0;
    assign sel_ok = onehot_check(32'(sel_op));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            winner_q <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_on_q <= 1'b0;
            in_sel_q <= IN_SEL_RESET;
            busy_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            res_q[0] <= '0;
            res_q[1] <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            alu_on_q <= 1'b1;
            in_sel_q <= IN_SEL_PERSIST;

            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        winner_q        <= arb_win;
                        gnt_q[arb_win]  <= 1'b1;
                        busy_q          <= 1'b1;
                        if (sel_ok) begin
                            // Operand registers drive the ALU directly, so
                            // they only change when a real load follows.
                            op_q     <= sel_op;
                            a_q      <= sel_a;
                            b_q      <= sel_b;
                            in_sel_q <= IN_SEL_LOAD;
                            state_q  <= ST_LOAD;
                        end else begin
                            res_q[arb_win]  <= '0;
                            done_q[arb_win] <= 1'b1;
                            err_q[arb_win]  <= 1'b1;
                            state_q         <= ST_RESP;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= CNT_W'(EXEC_CYCLES - 1);
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        res_q[winner_q]  <= alu_out;
                        done_q[winner_q] <= 1'b1;
                        state_q          <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
`ifndef ARB_FIXED_PRIO_EN
                    ptr_q   <= !winner_q;
`endif
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign done0       = done_q[0];
    assign done1       = done_q[1];
    assign err0        = err_q[0];
    assign err1        = err_q[1];
    assign res0        = res_q[0];
    assign res1        = res_q[1];
    assign alu_on      = alu_on_q;
    assign alu_in_sel  = in_sel_q;
    assign alu_num1    = a_q;
    assign alu_num2    = b_q;
    assign alu_out_sel = op_q;
    assign busy        = busy_q;
    assign state       = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: main instance with EXEC_CYCLES=2, second with EXEC_CYCLES=1.
// Honours ARB_FIXED_PRIO_EN for the contention expectations.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       req0 = 0, req1 = 0;
    logic [6:0] op0 = 0, op1 = 0;
    logic [7:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
    logic       gnt0, gnt1, done0, done1, err0, err1, alu_on, busy;
    logic [7:0] res0, res1, alu_num1, alu_num2, alu_out;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [1:0] state;

    logic       q_req0 = 0;
    logic [6:0] q_op0 = 0;
    logic [7:0] q_a0 = 0, q_b0 = 0;
    logic       q_gnt0, q_gnt1, q_done0, q_done1, q_err0, q_err1, q_alu_on, q_busy;
    logic [7:0] q_res0, q_res1, q_alu_num1, q_alu_num2, q_alu_out;
    logic [2:0] q_alu_in_sel;
    logic [6:0] q_alu_out_sel;
    logic [1:0] q_state;

    function automatic logic [7:0] alu_model(input logic [7:0] x, input logic [7:0] y,
                                             input logic [6:0] sel);
        case (sel)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_NOT:  return ~x;
            OP_PASS: return x;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out   = alu_model(alu_num1, alu_num2, alu_out_sel);
    assign q_alu_out = alu_model(q_alu_num1, q_alu_num2, q_alu_out_sel);

    alu_share_ctrl #(.WIDTH(8), .OPW(7), .EXEC_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .res0(res0), .res1(res1),
        .alu_on(alu_on), .alu_in_sel(alu_in_sel),
        .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_out_sel(alu_out_sel), .alu_out(alu_out),
        .busy(busy), .state(state)
    );

    alu_share_ctrl #(.WIDTH(8), .OPW(7), .EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(q_req0), .req1(1'b0), .op0(q_op0), .op1(7'd0),
        .a0(q_a0), .a1(8'd0), .b0(q_b0), .b1(8'd0),
        .gnt0(q_gnt0), .gnt1(q_gnt1), .done0(q_done0), .done1(q_done1),
        .err0(q_err0), .err1(q_err1), .res0(q_res0), .res1(q_res1),
        .alu_on(q_alu_on), .alu_in_sel(q_alu_in_sel),
        .alu_num1(q_alu_num1), .alu_num2(q_alu_num2),
        .alu_out_sel(q_alu_out_sel), .alu_out(q_alu_out),
        .busy(q_busy), .state(q_state)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low
        tick(); tick();
        chk("rst_in_sel",  32'(alu_in_sel), 32'(3'b001));
        chk("rst_alu_on",  32'(alu_on), 32'd0);
        chk("rst_gnt0",    32'(gnt0), 32'd0);
        chk("rst_done0",   32'(done0), 32'd0);
        chk("rst_err1",    32'(err1), 32'd0);
        chk("rst_state",   32'(state), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_res0",    32'(res0), 32'd0);
        chk("rst_num1",    32'(alu_num1), 32'd0);
        chk("rst_outsel",  32'(alu_out_sel), 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_in_sel",  32'(alu_in_sel), 32'(3'b100));
        chk("rel_alu_on",  32'(alu_on), 32'd1);
        chk("rel_state",   32'(state), 32'd0);

        // Single add from requester 0
        req0 = 1'b1; op0 = OP_ADD; a0 = 8'h57; b0 = 8'h1A;
        tick();
        chk("s_gnt0",      32'(gnt0), 32'd1);
        chk("s_gnt1",      32'(gnt1), 32'd0);
        chk("s_state_ld",  32'(state), 32'd1);
        chk("s_in_sel_ld", 32'(alu_in_sel), 32'(3'b010));
        chk("s_num1",      32'(alu_num1), 32'h57);
        chk("s_num2",      32'(alu_num2), 32'h1A);
        chk("s_outsel",    32'(alu_out_sel), 32'h40);
        chk("s_busy",      32'(busy), 32'd1);
        req0 = 1'b0;
        tick();
        chk("s_state_ex",  32'(state), 32'd2);
        chk("s_in_sel_ex", 32'(alu_in_sel), 32'(3'b100));
        chk("s_gnt0_off",  32'(gnt0), 32'd0);
        tick();
        chk("s_done_early", 32'(done0), 32'd0);
        tick();
        chk("s_done0",     32'(done0), 32'd1);
        chk("s_res0",      32'(res0), 32'h71);
        chk("s_err0",      32'(err0), 32'd0);
        chk("s_state_rsp", 32'(state), 32'd3);
        tick();
        chk("s_done_off",  32'(done0), 32'd0);
        chk("s_state_idl", 32'(state), 32'd0);
        chk("s_busy_off",  32'(busy), 32'd0);
        chk("s_num1_hold", 32'(alu_num1), 32'h57);

        // Requester 1 subtract; res0 must hold
        req1 = 1'b1; op1 = OP_SUB; a1 = 8'h20; b1 = 8'h05;
        tick();
        chk("h_gnt1",      32'(gnt1), 32'd1);
        req1 = 1'b0;
        tick(); tick(); tick();
        chk("h_done1",     32'(done1), 32'd1);
        chk("h_res1",      32'(res1), 32'h1B);
        chk("h_res0_hold", 32'(res0), 32'h71);
        tick();

        // Bad opcode from requester 1
        req1 = 1'b1; op1 = 7'b0000011; a1 = 8'hFF; b1 = 8'hFF;
        tick();
        chk("b_gnt1",      32'(gnt1), 32'd1);
        chk("b_state",     32'(state), 32'd3);
        chk("b_in_sel",    32'(alu_in_sel), 32'(3'b100));
        chk("b_done1",     32'(done1), 32'd1);
        chk("b_err1",      32'(err1), 32'd1);
        chk("b_res1",      32'(res1), 32'd0);
        chk("b_num1_hold", 32'(alu_num1), 32'h20);
        req1 = 1'b0;
        tick();
        chk("b_state_idl", 32'(state), 32'd0);
        chk("b_err_off",   32'(err1), 32'd0);

        // Contention, both held across three rounds
        req0 = 1'b1; op0 = OP_AND; a0 = 8'hF0; b0 = 8'h3C;
        req1 = 1'b1; op1 = OP_OR;  a1 = 8'hF0; b1 = 8'h0F;
        tick();
        chk("c1_gnt0",     32'(gnt0), 32'd1);
        chk("c1_gnt1",     32'(gnt1), 32'd0);
        tick(); tick(); tick();
        chk("c1_done0",    32'(done0), 32'd1);
        chk("c1_res0",     32'(res0), 32'h30);
        chk("c1_done1",    32'(done1), 32'd0);
        tick(); tick();
        chk("c2_gnt0",     32'(gnt0), 32'(FIXED));
        chk("c2_gnt1",     32'(gnt1), 32'(!FIXED));
        tick(); tick(); tick();
        chk("c2_done1",    32'(done1), 32'(!FIXED));
        chk("c2_res1",     32'(res1), FIXED ? 32'h00 : 32'hFF);
        chk("c2_res0",     32'(res0), 32'h30);
        tick(); tick();
        chk("c3_gnt0",     32'(gnt0), 32'd1);
        chk("c3_gnt1",     32'(gnt1), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick();
        chk("c3_done0",    32'(done0), 32'd1);
        tick();

        // Reset during EXEC drops the operation
        req0 = 1'b1; op0 = OP_ADD; a0 = 8'h01; b0 = 8'h02;
        tick();
        req0 = 1'b0;
        tick();
        chk("r_state_ex",  32'(state), 32'd2);
        rst = 1'b0;
        #1;
        chk("r_state",     32'(state), 32'd0);
        chk("r_in_sel",    32'(alu_in_sel), 32'(3'b001));
        chk("r_alu_on",    32'(alu_on), 32'd0);
        chk("r_busy",      32'(busy), 32'd0);
        chk("r_res0",      32'(res0), 32'd0);
        tick(); tick();
        chk("r_no_done",   32'(done0), 32'd0);
        rst = 1'b1;
        tick();
        req0 = 1'b1;
        tick();
        chk("r2_gnt0",     32'(gnt0), 32'd1);
        req0 = 1'b0;
        tick(); tick(); tick();
        chk("r2_done0",    32'(done0), 32'd1);
        chk("r2_res0",     32'(res0), 32'h03);
        tick();

        // EXEC_CYCLES=1 instance: done three cycles after sampling edge
        q_req0 = 1'b1; q_op0 = OP_ADD; q_a0 = 8'h10; q_b0 = 8'h20;
        tick();
        chk("e1_gnt0",     32'(q_gnt0), 32'd1);
        chk("e1_state_ld", 32'(q_state), 32'd1);
        q_req0 = 1'b0;
        tick();
        chk("e1_done_early", 32'(q_done0), 32'd0);
        chk("e1_state_ex", 32'(q_state), 32'd2);
        tick();
        chk("e1_done0",    32'(q_done0), 32'd1);
        chk("e1_res0",     32'(q_res0), 32'h30);
        tick();
        chk("e1_done_off", 32'(q_done0), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
